// File: rtl/lcv_div_rem.sv
// Signed truncating divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per cycle, with divide-by-zero and MIN/-1 overflow short cuts.
module lcv_div_rem #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DIVIDEND_W-1:0] quot,
    output logic signed [DIVISOR_W-1:0]  rem,
    output logic                         div_zero,
    output logic                         ovf
);

    localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] MIN_DVD = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                       r_state;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic [DIVIDEND_W-1:0]        r_dvd;
    logic [DIVISOR_W-1:0]         r_dvs;
    logic [DIVISOR_W:0]           r_prem;
    logic                         r_neg_q;
    logic                         r_neg_r;
    logic [CW-1:0]                r_cnt;
    logic                         r_fin;
    logic signed [DIVIDEND_W-1:0] r_quot;
    logic signed [DIVISOR_W-1:0]  r_rem;
    logic                         r_dz;
    logic                         r_ovf;

    logic [DIVIDEND_W-1:0]  w_dvd_u;
    logic [DIVISOR_W-1:0]   w_dvs_u;
    logic [DIVIDEND_W-1:0]  w_dvd_mag;
    logic [DIVISOR_W-1:0]   w_dvs_mag;
    logic                   w_dz;
    logic                   w_ovf;
    logic [DIVISOR_W+1:0]   w_trial;
    logic [DIVISOR_W+1:0]   w_diff;
    logic                   w_ge;
    logic [DIVISOR_W:0]     w_prem_nxt;
    logic [DIVIDEND_W-1:0]  w_dvd_nxt;

    assign w_dvd_u   = dividend;
    assign w_dvs_u   = divisor;
    assign w_dvd_mag = w_dvd_u[DIVIDEND_W-1] ? (~w_dvd_u + DIVIDEND_W'(1)) : w_dvd_u;
    assign w_dvs_mag = w_dvs_u[DIVISOR_W-1]  ? (~w_dvs_u + DIVISOR_W'(1))  : w_dvs_u;
    assign w_dz      = (w_dvs_u == '0);
    assign w_ovf     = (w_dvd_u == MIN_DVD) && (&w_dvs_u);

    // Shift the next dividend bit into the partial remainder; a borrow out of
    // the trial subtraction means the divisor did not fit (restore).
    assign w_trial    = {r_prem, r_dvd[DIVIDEND_W-1]};
    assign w_diff     = w_trial - {2'b00, r_dvs};
    assign w_ge       = ~w_diff[DIVISOR_W+1];
    assign w_prem_nxt = w_ge ? w_diff[DIVISOR_W:0] : w_trial[DIVISOR_W:0];
    assign w_dvd_nxt  = {r_dvd[DIVIDEND_W-2:0], w_ge};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_cnt       <= '0;
            r_fin       <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (r_in_ready && in_valid) begin
                        r_in_ready <= 1'b0;
                        r_dvd      <= w_dvd_mag;
                        r_dvs      <= w_dvs_mag;
                        r_prem     <= '0;
                        r_neg_q    <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                        r_neg_r    <= dividend[DIVIDEND_W-1];
                        r_cnt      <= CNT_INIT;
                        r_fin      <= 1'b0;
                        if (w_dz) begin
                            r_state <= DONE;
                            r_quot  <= '1;
                            r_rem   <= dividend[DIVISOR_W-1:0];
                            r_dz    <= 1'b1;
                            r_ovf   <= 1'b0;
                        end else if (w_ovf) begin
                            r_state <= DONE;
                            r_quot  <= dividend;
                            r_rem   <= '0;
                            r_dz    <= 1'b0;
                            r_ovf   <= 1'b1;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (r_fin) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_quot      <= r_neg_q ? (~r_dvd + DIVIDEND_W'(1)) : r_dvd;
                        r_rem       <= r_neg_r ? (~r_prem[DIVISOR_W-1:0] + DIVISOR_W'(1))
                                               : r_prem[DIVISOR_W-1:0];
                        r_dz        <= 1'b0;
                        r_ovf       <= 1'b0;
                    end else begin
                        r_dvd  <= w_dvd_nxt;
                        r_prem <= w_prem_nxt;
                        if (r_cnt == '0) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                DONE: begin
                    // Short-cut results land here one edge before out_valid rises.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quot      = r_quot;
    assign rem       = r_rem;
    assign div_zero  = r_dz;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_lcv_div_rem.sv
// Bench for lcv_div_rem: directed corner cases plus randomized operands checked
// against an arithmetic model of signed truncating division.
module tb_lcv_div_rem;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] dividend  = '0;
    logic [15:0] divisor   = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] quot;
    logic [15:0] rem;
    logic        div_zero;
    logic        ovf;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcv_div_rem #(
        .DIVIDEND_W(32),
        .DIVISOR_W (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic dz, output logic ov);
        longint la;
        longint lb;
        longint lq;
        longint lr;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (lb == 0) begin
            q  = 32'hFFFF_FFFF;
            r  = a[15:0];
            dz = 1'b1;
        end else if (la == -64'sd2147483648 && lb == -64'sd1) begin
            q  = a;
            r  = 16'h0000;
            ov = 1'b1;
        end else begin
            lq = la / lb;
            lr = la % lb;
            q  = lq[31:0];
            r  = lr[15:0];
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int hold,
                          input logic [31:0] eq, input logic [15:0] er,
                          input logic edz, input logic eov, input int elat);
        int guard;
        int lat;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        chk("in_ready_busy", in_ready, 0);
        chk("valid_at_accept", out_valid, 0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (out_valid !== 1'b1 && lat < 100);
        chk("latency", lat, elat);
        chk("quot", quot, eq);
        chk("rem", rem, er);
        chk("div_zero", div_zero, edz);
        chk("ovf", ovf, eov);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_quot", quot, eq);
            chk("hold_rem", rem, er);
            chk("hold_flags", {div_zero, ovf}, {edz, eov});
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_after_take", out_valid, 0);
        chk("in_ready_after_take", in_ready, 1);
    endtask

    task automatic run_rand(input logic [31:0] a, input logic [15:0] b, input int hold);
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        model(a, b, q, r, dz, ov);
        run_op(a, b, hold, q, r, dz, ov, (dz || ov) ? 1 : 33);
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [15:0] rb;

        #3 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_flags", {div_zero, ovf}, 2'b00);
        @(posedge clk); #1;
        chk("rst_hold_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", in_ready, 1);

        run_op(32'd100, 16'd7, 0, 32'd14, 16'd2, 1'b0, 1'b0, 33);
        run_op(32'hFFFF_FF9C, 16'd7, 0, 32'hFFFF_FFF2, 16'hFFFE, 1'b0, 1'b0, 33);
        run_op(32'd100, 16'hFFF9, 0, 32'hFFFF_FFF2, 16'd2, 1'b0, 1'b0, 33);
        run_op(32'd100, 16'd0, 0, 32'hFFFF_FFFF, 16'd100, 1'b1, 1'b0, 1);
        run_op(32'h8000_0000, 16'hFFFF, 0, 32'h8000_0000, 16'd0, 1'b0, 1'b1, 1);
        run_op(32'h8000_0000, 16'h8000, 0, 32'd65536, 16'd0, 1'b0, 1'b0, 33);
        run_op(32'd12345, 16'd67, 10, 32'd184, 16'd17, 1'b0, 1'b0, 33);

        // Reset in the middle of a calculation.
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 16'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_quot", quot, 0);
        chk("mid_rst_rem", rem, 0);
        chk("mid_rst_flags", {div_zero, ovf}, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("stale_valid", seen, 0);
        run_op(32'd7, 16'd2, 0, 32'd3, 16'd1, 1'b0, 1'b0, 33);

        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 6))
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                2:       rb = 16'h8000;
                3:       rb = 16'($urandom_range(1, 20));
                4:       rb = -16'($urandom_range(1, 20));
                default: rb = 16'($urandom);
            endcase
            run_rand(ra, rb, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
